// File: rtl/move_generator.sv
// -----------------------------------------------------------------------------
// move_generator
//
// Sequential move enumerator. Given a piece code and its source square, it
// walks the piece's direction table, reads the board RAM for every candidate
// square and streams each pseudo-legal target square over a valid/ready
// handshake. Sliding rays stop at the first occupied square; captures are only
// offered on enemy pieces. Geometry is row/column based, so rays never wrap
// around a board edge.
//
// Parameters:
//   READ_LATENCY    cycles from boardAddr change to valid boardPiece (1 or 2)
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   start           one-cycle pulse, sampled only while idle
//   currentPosition source square: row = [5:3] (0 = top), col = [2:0]
//   currentPiece    [3] colour (1 = black), [2:0] kind
//                   (0 empty, 1 king, 2 queen, 3 bishop, 4 knight, 5 rook, 6 pawn)
//   boardAddr       board RAM read address
//   boardPiece      board RAM read data
//   targetPosition  emitted target square
//   targetValid     targetPosition valid
//   targetReady     consumer accepts when targetValid && targetReady
//   busy            high from the cycle after an accepted start until done
//   done            one-cycle pulse at the end of enumeration
//   moveCount       targets accepted in this run, held until the next start
//   targetCapture   emitted square holds an enemy piece (optional feature)
//
// Build option:
//   MOVEGEN_CAPTURE_FLAG_EN  when defined, targetCapture flags captures;
//                            otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module move_generator #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] currentPosition,
  input  logic [3:0] currentPiece,
  output logic [5:0] boardAddr,
  input  logic [3:0] boardPiece,
  output logic [5:0] targetPosition,
  output logic       targetValid,
  input  logic       targetReady,
  output logic       busy,
  output logic       done,
  output logic [5:0] moveCount,
  output logic       targetCapture
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STEP, S_WAIT, S_EVAL, S_EMIT, S_NEXTDIR, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_EMPTY, K_KING, K_QUEEN, K_BISHOP, K_KNIGHT, K_ROOK, K_PAWN, K_INVALID
  } kind_t;

  // Three-bit two's complement step sizes.
  localparam logic [2:0] P1 = 3'b001, P2 = 3'b010, Z0 = 3'b000;
  localparam logic [2:0] M1 = 3'b111, M2 = 3'b110;

  state_t     state_q, state_d;
  logic [5:0] src_q, src_d;
  logic [3:0] piece_q, piece_d;
  logic [4:0] row_q, row_d, col_q, col_d;   // ray cursor, room for off-board
  logic [2:0] dir_q, dir_d;
  logic [1:0] lat_q, lat_d;
  logic [5:0] addr_q, addr_d;
  logic [5:0] tgt_q, tgt_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] count_q, count_d;
  logic       empty_q, empty_d;             // emitted square was empty
  logic       fwd_empty_q, fwd_empty_d;     // pawn single-step square empty
`ifdef MOVEGEN_CAPTURE_FLAG_EN
  logic       cap_q, cap_d;
`endif

  kind_t      kind;
  logic       slider, last_dir, pawn_skip, off_board;
  logic       sq_empty, sq_enemy, allowed;
  logic [2:0] qd, dr, dc;
  logic [4:0] next_row, next_col;

  assign kind   = kind_t'(piece_q[2:0]);
  assign slider = (kind == K_QUEEN) || (kind == K_BISHOP) || (kind == K_ROOK);
  // Rook, bishop and pawn use four table entries; the rest use eight.
  assign last_dir = ((kind == K_ROOK) || (kind == K_BISHOP) || (kind == K_PAWN))
                    ? (dir_q == 3'd3) : (dir_q == 3'd7);

  // Step vector for the current direction index.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dr = Z0;
    dc = Z0;
    case (kind)
      K_ROOK:   qd = {dir_q[1:0], 1'b0};
      K_BISHOP: qd = {dir_q[1:0], 1'b1};
      default:  qd = dir_q;
    endcase
    if (kind == K_KNIGHT) begin
      case (dir_q)
        3'd0: begin dr = M2; dc = P1; end
        3'd1: begin dr = M1; dc = P2; end
        3'd2: begin dr = P1; dc = P2; end
        3'd3: begin dr = P2; dc = P1; end
        3'd4: begin dr = P2; dc = M1; end
        3'd5: begin dr = P1; dc = M2; end
        3'd6: begin dr = M1; dc = M2; end
        default: begin dr = M2; dc = M1; end
      endcase
    end else if (kind == K_PAWN) begin
      // Forward is toward row 7 for black and toward row 0 for white.
      dr = piece_q[3] ? P1 : M1;
      case (dir_q[1:0])
        2'd0: dc = Z0;
        2'd1: begin dr = piece_q[3] ? P2 : M2; dc = Z0; end
        2'd2: dc = M1;
        default: dc = P1;
      endcase
    end else begin
      case (qd)
        3'd0: begin dr = M1; dc = Z0; end
        3'd1: begin dr = M1; dc = P1; end
        3'd2: begin dr = Z0; dc = P1; end
        3'd3: begin dr = P1; dc = P1; end
        3'd4: begin dr = P1; dc = Z0; end
        3'd5: begin dr = P1; dc = M1; end
        3'd6: begin dr = Z0; dc = M1; end
        default: begin dr = M1; dc = M1; end
      endcase
    end
  end

  assign next_row  = row_q + {{2{dr[2]}}, dr};
  assign next_col  = col_q + {{2{dc[2]}}, dc};
  // Cursor range is -2..9, so any set bit above [2:0] means off-board.
  assign off_board = (|next_row[4:3]) || (|next_col[4:3]);
  // Double step needs the home row and an empty single-step square; otherwise
  // the candidate is dropped without touching the board RAM.
  assign pawn_skip = (kind == K_PAWN) && (dir_q == 3'd1) &&
                     !(fwd_empty_q && (src_q[5:3] == (piece_q[3] ? 3'd1 : 3'd6)));

  assign sq_empty = (boardPiece[2:0] == 3'd0);
  assign sq_enemy = !sq_empty && (boardPiece[3] != piece_q[3]);
  // Pawn pushes need an empty square, pawn diagonals need an enemy.
  assign allowed  = (kind == K_PAWN) ? (dir_q[1] ? sq_enemy : sq_empty)
                                     : (sq_empty || sq_enemy);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    piece_d     = piece_q;
    row_d       = row_q;
    col_d       = col_q;
    dir_d       = dir_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    tgt_d       = tgt_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    count_d     = count_q;
    empty_d     = empty_q;
    fwd_empty_d = fwd_empty_q;
`ifdef MOVEGEN_CAPTURE_FLAG_EN
    cap_d       = cap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = currentPosition;
          piece_d = currentPiece;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        count_d     = 6'd0;
        dir_d       = 3'd0;
        row_d       = {2'b00, src_q[5:3]};
        col_d       = {2'b00, src_q[2:0]};
        fwd_empty_d = 1'b0;
        if ((kind == K_EMPTY) || (kind == K_INVALID)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (off_board || pawn_skip) begin
          state_d = S_NEXTDIR;
        end else begin
          row_d   = next_row;
          col_d   = next_col;
          addr_d  = {next_row[2:0], next_col[2:0]};
          lat_d   = 2'(READ_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd0) state_d = S_EVAL;
        else               lat_d   = lat_q - 2'd1;
      end
      S_EVAL: begin
        if ((kind == K_PAWN) && (dir_q == 3'd0)) fwd_empty_d = sq_empty;
        if (allowed) begin
          tgt_d   = addr_q;
          valid_d = 1'b1;
          empty_d = sq_empty;
`ifdef MOVEGEN_CAPTURE_FLAG_EN
          cap_d   = sq_enemy;
`endif
          state_d = S_EMIT;
        end else begin
          state_d = S_NEXTDIR;
        end
      end
      S_EMIT: begin
        if (targetReady) begin
          valid_d = 1'b0;
          count_d = count_q + 6'd1;
`ifdef MOVEGEN_CAPTURE_FLAG_EN
          cap_d   = 1'b0;
`endif
          state_d = (slider && empty_q) ? S_STEP : S_NEXTDIR;
        end
      end
      S_NEXTDIR: begin
        row_d = {2'b00, src_q[5:3]};
        col_d = {2'b00, src_q[2:0]};
        if (last_dir) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = S_STEP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= 6'd0;
      piece_q     <= 4'd0;
      row_q       <= 5'd0;
      col_q       <= 5'd0;
      dir_q       <= 3'd0;
      lat_q       <= 2'd0;
      addr_q      <= 6'd0;
      tgt_q       <= 6'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 6'd0;
      empty_q     <= 1'b0;
      fwd_empty_q <= 1'b0;
`ifdef MOVEGEN_CAPTURE_FLAG_EN
      cap_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      piece_q     <= piece_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      tgt_q       <= tgt_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      fwd_empty_q <= fwd_empty_d;
`ifdef MOVEGEN_CAPTURE_FLAG_EN
      cap_q       <= cap_d;
`endif
    end
  end

  assign boardAddr      = addr_q;
  assign targetPosition = tgt_q;
  assign targetValid    = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign moveCount      = count_q;
`ifdef MOVEGEN_CAPTURE_FLAG_EN
  assign targetCapture  = cap_q;
`else
  assign targetCapture  = 1'b0;
`endif

endmodule

// File: tb/tb_move_generator.sv
// -----------------------------------------------------------------------------
// tb_move_generator
//
// Drives two move_generator instances (READ_LATENCY 1 and 2) that share one
// board image; `sel` picks which instance receives start and whose outputs are
// observed. Expected targets go into a scoreboard queue before each run and are
// popped on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_move_generator;

  logic       clk = 1'b0;
  logic       reset, start, targetReady, sel;
  logic [5:0] currentPosition;
  logic [3:0] currentPiece;
  logic [3:0] board [64];

  logic [5:0] addr_a, tp_a, cnt_a, addr_b, tp_b, cnt_b;
  logic       tv_a, busy_a, done_a, cap_a, tv_b, busy_b, done_b, cap_b;
  logic [3:0] rd1_a, rd1_b, rd2_b;
  logic       start_a, start_b;

  logic [5:0] o_addr, o_tp, o_cnt;
  logic       o_tv, o_busy, o_done, o_cap;

  typedef struct {
    logic [5:0] pos;
    logic       cap;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  // Board RAM read ports: one and two cycles of latency.
  always @(posedge clk) begin
    rd1_a <= board[addr_a];
    rd1_b <= board[addr_b];
    rd2_b <= rd1_b;
  end

  always_comb begin
    o_addr = sel ? addr_b : addr_a;
    o_tp   = sel ? tp_b   : tp_a;
    o_cnt  = sel ? cnt_b  : cnt_a;
    o_tv   = sel ? tv_b   : tv_a;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_cap  = sel ? cap_b  : cap_a;
  end

  move_generator #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .currentPosition(currentPosition), .currentPiece(currentPiece),
    .boardAddr(addr_a), .boardPiece(rd1_a),
    .targetPosition(tp_a), .targetValid(tv_a), .targetReady(targetReady),
    .busy(busy_a), .done(done_a), .moveCount(cnt_a), .targetCapture(cap_a)
  );

  move_generator #(.READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .currentPosition(currentPosition), .currentPiece(currentPiece),
    .boardAddr(addr_b), .boardPiece(rd2_b),
    .targetPosition(tp_b), .targetValid(tv_b), .targetReady(targetReady),
    .busy(busy_b), .done(done_b), .moveCount(cnt_b), .targetCapture(cap_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input bit c);
    exp_t e;
    e.pos = 6'(p);
    e.cap = c;
    sb.push_back(e);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
  endtask

  // Empty-board rays from (r0,c0) for every direction whose mask bit is set.
  task automatic push_rays(input int r0, input int c0, input logic [7:0] mask);
    int drs [8];
    int dcs [8];
    int r, c;
    drs = '{-1, -1, 0, 1, 1, 1, 0, -1};
    dcs = '{ 0, 1, 1, 1, 0, -1, -1, -1};
    for (int d = 0; d < 8; d++) begin
      if (mask[d]) begin
        r = r0 + drs[d];
        c = c0 + dcs[d];
        while (r >= 0 && r < 8 && c >= 0 && c < 8) begin
          push(r * 8 + c, 1'b0);
          r += drs[d];
          c += dcs[d];
        end
      end
    end
  endtask

  // One enumeration run. Starts at a negedge and ends at a negedge.
  task automatic run(input logic [3:0] pc, input logic [5:0] pos, input int exp_cnt,
                     input int stall, input int abort_after);
    int         accepted = 0;
    int         stall_left = stall;
    int         cyc = 0;
    bit         got_done = 0;
    bit         holding = 0;
    logic [5:0] held = 6'd0;
    exp_t       e;
    @(negedge clk);
    currentPiece    = pc;
    currentPosition = pos;
    start           = 1'b1;
    targetReady     = 1'b1;
    @(negedge clk);
    start           = 1'b0;
    currentPiece    = ~pc;   // must be ignored while busy
    currentPosition = ~pos;
    check("busy_after_start", o_busy, 1);
    while (!got_done && cyc < 3000) begin
      if (abort_after > 0 && accepted == abort_after) return;
      if (o_done) begin
        got_done = 1;
      end else begin
        if (stall_left > 0 && (holding || o_tv)) begin
          targetReady = 1'b0;
          if (holding) begin
            check("stall_valid", o_tv, 1);
            check("stall_pos", o_tp, held);
          end else begin
            held    = o_tp;
            holding = 1;
          end
          stall_left--;
        end else begin
          targetReady = 1'b1;
          if (o_tv) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("target", o_tp, e.pos);
`ifdef MOVEGEN_CAPTURE_FLAG_EN
              check("capture", o_cap, e.cap);
`else
              check("capture", o_cap, 0);
`endif
            end
            accepted++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", got_done, 1);
    check("move_count", o_cnt, exp_cnt);
    check("accepted", accepted, exp_cnt);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    // A start coinciding with done must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_once", o_done, 0);
    check("busy_after_done", o_busy, 0);
    @(negedge clk);
    check("start_at_done_ignored", o_busy, 0);
    check("count_held", o_cnt, exp_cnt);
  endtask

  initial begin
    bit saw_done;
    reset           = 1'b1;
    start           = 1'b0;
    targetReady     = 1'b0;
    sel             = 1'b0;
    currentPiece    = 4'd0;
    currentPosition = 6'd0;
    clear_board();
    repeat (3) @(negedge clk);
    check("rst_valid", o_tv, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_count", o_cnt, 0);
    check("rst_addr", o_addr, 0);
    check("rst_target", o_tp, 0);
    check("rst_capture", o_cap, 0);
    check("rst_valid_b", tv_b, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;

    // White knight in the corner.
    push(10, 0); push(17, 0);
    run(4'b0100, 6'd0, 2, 0, 0);

    // White rook in the opposite corner.
    push_rays(7, 7, 8'b0101_0101);
    run(4'b0101, 6'd63, 14, 0, 0);

    // White bishop: blocked by a friend, captures a black pawn.
    board[27] = 4'b1110;
    board[45] = 4'b0110;
    push(29, 0); push(22, 0); push(15, 0); push(43, 0); push(50, 0); push(57, 0);
    push(27, 1);
    run(4'b0011, 6'd36, 7, 0, 0);

    // White pawn on its home row, black knight on a capture diagonal.
    clear_board();
    board[43] = 4'b1100;
    push(44, 0); push(36, 0); push(43, 1);
    run(4'b0110, 6'd52, 3, 0, 0);

    // Same with the forward square occupied by an enemy: no push, no double.
    board[44] = 4'b1101;
    push(43, 1);
    run(4'b0110, 6'd52, 1, 0, 0);

    // Black pawn moves downward; white knight on the right diagonal.
    clear_board();
    board[21] = 4'b0100;
    push(20, 0); push(28, 0); push(21, 1);
    run(4'b1110, 6'd12, 3, 0, 0);

    // White king in a corner with a friendly piece beside it.
    clear_board();
    board[6] = 4'b0110;
    push(15, 0); push(14, 0);
    run(4'b0001, 6'd7, 2, 0, 0);

    // Queen with backpressure on the first target, both read latencies.
    clear_board();
    push_rays(3, 3, 8'hFF);
    run(4'b0010, 6'd27, 27, 5, 0);
    sel = 1'b1;
    push_rays(3, 3, 8'hFF);
    run(4'b0010, 6'd27, 27, 5, 0);
    sel = 1'b0;

    // Reset in the middle of a run.
    push_rays(3, 3, 8'hFF);
    run(4'b0010, 6'd27, 27, 0, 3);
    reset       = 1'b1;
    targetReady = 1'b0;
    @(negedge clk);
    check("abort_valid", o_tv, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    reset    = 1'b0;
    sb.delete();
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);

    // Empty-square piece code: immediate done with zero moves.
    run(4'b1000, 6'd10, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/move_generator.md
Name: move_generator

Overview:
- Sequential move enumerator: given a piece code and its square, streams every pseudo-legal target square, one per valid/ready handshake.
- Geometry is row/column based, so there is no board-edge wrap-around.
- Reads the board-state RAM to stop sliding rays at occupied squares and to allow captures of enemy pieces only.
- Sits between the board RAM and move-selection/highlight logic, alongside the per-move legality checks.

Parameters:
READ_LATENCY, 1, cycles from boardAddr change to valid boardPiece (supported: 1 or 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
currentPosition  in  6  source square; row = [5:3] (0 = top), col = [2:0]; white plays from the bottom
currentPiece  in  4  piece code; [3] = colour (1 = black); [2:0]: 0 empty, 1 king, 2 queen, 3 bishop, 4 knight, 5 rook, 6 pawn
boardAddr  out  6  board RAM read address
boardPiece  in  4  board RAM read data, READ_LATENCY cycles after boardAddr
targetPosition  out  6  emitted target square
targetValid  out  1  targetPosition valid
targetReady  in  1  consumer accepts when targetValid && targetReady
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of enumeration
moveCount  out  6  targets accepted in this run; valid when done pulses, held until the next start
targetCapture  out  1  see Optional Feature

Behaviour:
- Reset values: targetValid 0, busy 0, done 0, moveCount 0, boardAddr 0, targetPosition 0, targetCapture 0; FSM to IDLE.
- Reset mid-run aborts immediately; no done pulse is produced.
- start and currentPosition/currentPiece are latched in IDLE; changes to them while busy are ignored.
- FSM states:
  - IDLE: on start go to SETUP.
  - SETUP: select direction table, clear moveCount, dirIdx = 0.
  - STEP: add (dr,dc) to the ray cursor.
    - Off-board (row or col outside 0..7): end the ray, go to NEXTDIR.
    - Otherwise drive boardAddr and go to WAIT.
  - WAIT: stay READ_LATENCY cycles, then EVAL.
  - EVAL: classify the square as empty (boardPiece[2:0] == 0), enemy, or friend.
    - Friend: end the ray.
    - Empty or enemy: go to EMIT.
  - EMIT: hold targetValid high and targetPosition stable until targetReady; on accept moveCount += 1.
    - Continue the ray (STEP) only if the piece is a slider and the square was empty; otherwise NEXTDIR.
  - NEXTDIR: dirIdx += 1, reset the cursor to the source square; go to DONE when directions are exhausted, else STEP.
  - DONE: pulse done for one cycle, busy low, then IDLE.
- A start pulse that coincides with done is ignored.
- Direction order, dir 0..7 as (dr,dc): (-1,0), (-1,+1), (0,+1), (+1,+1), (+1,0), (+1,-1), (0,-1), (-1,-1).
  - Rook: dirs 0,2,4,6.
  - Bishop: dirs 1,3,5,7.
  - Queen: dirs 0..7.
  - King: dirs 0..7, single step per direction.
- Knight order, single step each: (-2,+1), (-1,+2), (+1,+2), (+2,+1), (+2,-1), (+1,-2), (-1,-2), (-2,-1).
- Pawn, with f = -1 for white and +1 for black, in this order:
  - forward (f,0): emitted only if empty;
  - double (2f,0): only if the source row is 6 (white) or 1 (black) and both squares are empty;
  - capture (f,-1): only if enemy;
  - capture (f,+1): only if enemy.
  - If the forward square is not empty, the double-step candidate is skipped without a board read.
- currentPiece[2:0] of 0 or 7: SETUP goes directly to DONE, moveCount = 0.
- Maximum moveCount is 27 (queen); fits in 6 bits.

Optional Feature:
- Macro: MOVEGEN_CAPTURE_FLAG_EN.
- Defined: targetCapture = 1 alongside targetValid when the emitted square holds an enemy piece, else 0. It is registered in EVAL and held through EMIT.
- Undefined: targetCapture is tied to 0; no extra registers.

Test Plan:
- Empty board, white knight (0100) at 0, targetReady = 1 -> targets 10, 17 in order; moveCount 2; done pulses once.
- Empty board, white rook at 63 -> targets 55,47,39,31,23,15,7,62,61,60,59,58,57,56; moveCount 14.
- White bishop at 36, black pawn at 27, white pawn at 45 -> targets 29,22,15,43,50,57,27; moveCount 7; with MOVEGEN_CAPTURE_FLAG_EN, targetCapture = 1 only on 27.
- White pawn at 52, black knight at 43, otherwise empty -> targets 44, 36, 43; moveCount 3. Same with a piece at 44 -> target 43 only; moveCount 1.
- Backpressure: queen run with targetReady held low for 5 cycles on the first target -> targetValid and targetPosition stable throughout, no target skipped or duplicated, final moveCount 27 for a queen at 27 on an empty board. Repeat with READ_LATENCY = 2.
- Reset asserted mid-run after 3 accepts -> next cycle targetValid 0, busy 0, no done pulse. A following start with currentPiece 1000 -> done with moveCount 0.
